// File: rtl/dffram_arb_pkg.sv
// Shared types and defaults for the DFFRAM512x32 round-robin arbiter.
package dffram_arb_pkg;

    localparam int A_WIDTH  = 9;
    localparam int D_WIDTH  = 32;
    localparam int BE_WIDTH = 4;

    typedef enum logic [1:0] {ARB, LOCKED, DUMP} state_t;

    // Index width for n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dffram_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid bit at or after ptr, wrapping modulo N.
module rr_pick import dffram_arb_pkg::*; #(
    parameter int N  = 2,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int unsigned c;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            c = (32'(ptr) + k) % N;
            if (!any && valid[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = IW'(c);
            end
        end
    end

endmodule

// File: rtl/dffram_arbiter.sv
// Round-robin arbiter sharing one DFFRAM512x32 between NUM_REQ requesters, with locked bursts.
// Optional RAM dump sequencing is enabled by defining DFFRAM_ARB_DUMP_EN.
module dffram_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int A_WIDTH  = dffram_arb_pkg::A_WIDTH,
    parameter int D_WIDTH  = dffram_arb_pkg::D_WIDTH,
    parameter int MAX_LOCK = 8
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*(D_WIDTH/8)-1:0] req_we,
    input  logic [NUM_REQ*A_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*D_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [D_WIDTH-1:0]            rsp_rdata,
    output logic                          ram_en,
    output logic [(D_WIDTH/8)-1:0]        ram_we,
    output logic [A_WIDTH-1:0]            ram_a,
    output logic [D_WIDTH-1:0]            ram_di,
    input  logic [D_WIDTH-1:0]            ram_do,
`ifdef DFFRAM_ARB_DUMP_EN
    input  logic                          dump_req,
    output logic                          dump_done,
`endif
    output logic                          ram_write
);
    import dffram_arb_pkg::*;

    localparam int BE = D_WIDTH / 8;
    localparam int IW = clog2_min1(NUM_REQ);
    localparam int LW = clog2_min1(MAX_LOCK + 1);

    state_t              state, state_nx;
    logic [IW-1:0]       rr_ptr, rr_ptr_nx, owner, owner_nx;
    logic [LW-1:0]       lock_cnt, lock_cnt_nx;
    logic [NUM_REQ-1:0]  elig, pick_grant, grant;
    logic [IW-1:0]       pick_idx;
    logic                pick_any, fire, dump_go;
    logic [BE-1:0]       sel_we;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // While locked only the owner competes; in DUMP nobody does.
    always_comb begin
        elig = '0;
        if (state == ARB)         elig = req_valid;
        else if (state == LOCKED) elig = req_valid & (NUM_REQ'(1) << owner);
    end

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .valid (elig),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign fire      = RST_N && pick_any && !dump_go;
    assign grant     = fire ? pick_grant : '0;
    assign sel_we    = req_we[int'(pick_idx)*BE +: BE];
    assign req_ready = grant;
    assign ram_en    = fire;
    assign ram_we    = fire ? sel_we : '0;
    assign ram_a     = fire ? req_addr[int'(pick_idx)*A_WIDTH +: A_WIDTH] : '0;
    assign ram_di    = fire ? req_wdata[int'(pick_idx)*D_WIDTH +: D_WIDTH] : '0;
    assign rsp_rdata = ram_do;

    always_comb begin
        state_nx    = state;
        rr_ptr_nx   = rr_ptr;
        owner_nx    = owner;
        lock_cnt_nx = lock_cnt;
        unique case (state)
            ARB: begin
                if (dump_go) begin
                    state_nx = DUMP;
                end else if (fire) begin
                    rr_ptr_nx = wrap_inc(pick_idx);
                    if (req_lock[pick_idx] && MAX_LOCK > 1) begin
                        state_nx    = LOCKED;
                        owner_nx    = pick_idx;
                        lock_cnt_nx = LW'(1);
                    end
                end
            end
            LOCKED: begin
                if (fire) begin
                    lock_cnt_nx = lock_cnt + 1'b1;
                    if (!req_lock[owner] || lock_cnt_nx == LW'(MAX_LOCK)) begin
                        state_nx    = ARB;
                        rr_ptr_nx   = wrap_inc(owner);
                        lock_cnt_nx = '0;
                    end
                end
            end
            DUMP:    state_nx = ARB;
            default: state_nx = ARB;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ARB;
            rr_ptr    <= '0;
            owner     <= '0;
            lock_cnt  <= '0;
            rsp_valid <= '0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_ptr_nx;
            owner     <= owner_nx;
            lock_cnt  <= lock_cnt_nx;
            rsp_valid <= (fire && sel_we == '0) ? grant : '0;
        end
    end

`ifdef DFFRAM_ARB_DUMP_EN
    logic dump_armed;

    // dump_armed blocks re-entry until dump_req has been seen low.
    assign dump_go = (state == ARB) && dump_req && !dump_armed;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ram_write  <= 1'b0;
            dump_done  <= 1'b0;
            dump_armed <= 1'b0;
        end else begin
            ram_write <= dump_go;
            dump_done <= (state == DUMP);
            if (dump_go)       dump_armed <= 1'b1;
            else if (!dump_req) dump_armed <= 1'b0;
        end
    end
`else
    assign dump_go   = 1'b0;
    assign ram_write = 1'b0;
`endif

endmodule

// File: tb/tb_dffram_arbiter.sv
// Self-checking bench for dffram_arbiter with a behavioural RAM and arbitration model.
module tb_dffram_arbiter;

    localparam int N  = 2;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int BE = 4;
    localparam int ML = 8;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [N-1:0]    req_valid, req_lock;
    logic [N*BE-1:0] req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            ram_en, ram_write;
    logic [BE-1:0]   ram_we;
    logic [AW-1:0]   ram_a;
    logic [DW-1:0]   ram_di, ram_do;
`ifdef DFFRAM_ARB_DUMP_EN
    logic            dump_req, dump_done;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    dffram_arbiter #(.NUM_REQ(N), .A_WIDTH(AW), .D_WIDTH(DW), .MAX_LOCK(ML)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_lock(req_lock), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do),
`ifdef DFFRAM_ARB_DUMP_EN
        .dump_req(dump_req), .dump_done(dump_done),
`endif
        .ram_write(ram_write)
    );

    // DFFRAM512x32 behaviour: registered read, byte writes, Do0=0 when idle.
    logic [DW-1:0] ram_mem [512];
    always @(posedge CLK) begin
        if (ram_en) begin
            ram_do <= ram_mem[ram_a];
            for (int b = 0; b < BE; b++)
                if (ram_we[b]) ram_mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
        end else begin
            ram_do <= '0;
        end
    end

    // Reference model state
    logic [DW-1:0] gold [512];
    int            m_ptr, m_owner, m_cnt;
    bit            m_lock;
    logic [N-1:0]  exp_rsp;
    logic [DW-1:0] exp_data;

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_lock = 0; exp_rsp = '0; exp_data = '0;
    endtask

    function automatic int model_pick();
        if (m_lock) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_commit(input int g);
        logic [BE-1:0] we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        exp_rsp = '0;
        if (g < 0) return;
        we = req_we[g*BE +: BE];
        a  = req_addr[g*AW +: AW];
        d  = req_wdata[g*DW +: DW];
        if (we == '0) begin
            exp_rsp[g] = 1'b1;
            exp_data   = gold[a];
        end else begin
            for (int b = 0; b < BE; b++) if (we[b]) gold[a][8*b +: 8] = d[8*b +: 8];
        end
        if (m_lock) begin
            m_cnt++;
            if (!req_lock[g] || m_cnt == ML) begin m_lock = 0; m_ptr = (g + 1) % N; end
        end else begin
            m_ptr = (g + 1) % N;
            if (req_lock[g]) begin m_lock = 1; m_owner = g; m_cnt = 1; end
        end
    endtask

    task automatic set_req(input int r, input bit v, input bit lk, input logic [BE-1:0] we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[r] = v;
        req_lock[r]  = lk;
        req_we[r*BE +: BE]    = we;
        req_addr[r*AW +: AW]  = a;
        req_wdata[r*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_lock = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        clear_reqs();
        set_req(0, 1, 0, '0, 9'h010, '0);
        set_req(1, 1, 1, 4'hF, 9'h020, 32'h1);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        checks++; if (ram_en !== 1'b0 || ram_we !== '0 || ram_a !== '0 || ram_di !== '0) begin
            errors++; $display("FAIL reset_ram got en=%b we=%h a=%h di=%h exp all 0", ram_en, ram_we, ram_a, ram_di); end
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp got=%b exp=00", rsp_valid); end
        checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL reset_ram_write got=%b exp=0", ram_write); end
        RST_N = 1'b1;
        model_reset();
        clear_reqs();
        tick();
    endtask

    task automatic test_single_read();
        set_req(0, 1, 0, 4'hF, 9'h010, 32'hDEADBEEF);
        @(negedge CLK);
        checks++; if (req_ready !== 2'b01 || ram_en !== 1'b1 || ram_we !== 4'hF || ram_a !== 9'h010 || ram_di !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_write got rdy=%b en=%b we=%h a=%h di=%h exp rdy=01 en=1 we=f a=010 di=deadbeef",
                               req_ready, ram_en, ram_we, ram_a, ram_di); end
        model_commit(0); tick();
        set_req(0, 1, 0, '0, 9'h010, '0);
        @(negedge CLK);
        checks++; if (req_ready !== 2'b01 || ram_we !== '0 || rsp_valid !== '0) begin
            errors++; $display("FAIL single_read_grant got rdy=%b we=%h rsp=%b exp rdy=01 we=0 rsp=00", req_ready, ram_we, rsp_valid); end
        model_commit(0); tick();
        clear_reqs();
        @(negedge CLK);
        checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_read_rsp got rsp=%b data=%h exp rsp=01 data=deadbeef", rsp_valid, rsp_rdata); end
        model_commit(-1); tick();
    endtask

    task automatic test_byte_mask();
        set_req(0, 1, 0, 4'hF, 9'h1FF, 32'h11223344);
        @(negedge CLK);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mask_w0 got=%b exp=01", req_ready); end
        model_commit(0); tick();
        clear_reqs();
        set_req(1, 1, 0, 4'b0101, 9'h1FF, 32'hAABBCCDD);
        @(negedge CLK);
        checks++; if (req_ready !== 2'b10 || ram_we !== 4'b0101 || ram_di !== 32'hAABBCCDD) begin
            errors++; $display("FAIL mask_w1 got rdy=%b we=%b di=%h exp rdy=10 we=0101 di=aabbccdd", req_ready, ram_we, ram_di); end
        model_commit(1); tick();
        set_req(1, 1, 0, '0, 9'h1FF, '0);
        @(negedge CLK);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL mask_read_grant got=%b exp=10", req_ready); end
        model_commit(1); tick();
        clear_reqs();
        @(negedge CLK);
        checks++; if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h11BB33DD) begin
            errors++; $display("FAIL mask_read_rsp got rsp=%b data=%h exp rsp=10 data=11bb33dd", rsp_valid, rsp_rdata); end
        model_commit(-1); tick();
    endtask

    task automatic test_contention();
        int g;
        logic [N-1:0] er;
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < N; r++) set_req(r, 1, 0, '0, ($urandom_range(0, 1) != 0) ? 9'h010 : 9'h1FF, '0);
            @(negedge CLK);
            g  = model_pick();
            er = (g < 0) ? '0 : (N'(1) << g);
            checks++; if (req_ready !== er) begin errors++; $display("FAIL contention_grant cyc=%0d got=%b exp=%b", i, req_ready, er); end
            checks++; if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL contention_alternate cyc=%0d got=%b", i, req_ready); end
            checks++; if (rsp_valid !== exp_rsp || (exp_rsp != '0 && rsp_rdata !== exp_data)) begin
                errors++; $display("FAIL contention_rsp cyc=%0d got rsp=%b data=%h exp rsp=%b data=%h", i, rsp_valid, rsp_rdata, exp_rsp, exp_data); end
            model_commit(g); tick();
        end
        clear_reqs();
        @(negedge CLK);
        checks++; if (rsp_valid !== exp_rsp || rsp_rdata !== exp_data) begin
            errors++; $display("FAIL contention_last_rsp got rsp=%b data=%h exp rsp=%b data=%h", rsp_valid, rsp_rdata, exp_rsp, exp_data); end
        model_commit(-1); tick();
    endtask

    task automatic test_lock_cap();
        logic [N-1:0] er;
        for (int i = 0; i < 11; i++) begin
            set_req(0, 1, (i < 10), '0, 9'h010, '0);
            set_req(1, 1, 0, '0, 9'h1FF, '0);
            @(negedge CLK);
            er = (i == 8) ? 2'b10 : 2'b01;
            checks++; if (req_ready !== er) begin errors++; $display("FAIL lock_cap cyc=%0d got=%b exp=%b", i, req_ready, er); end
            checks++; if (rsp_valid !== exp_rsp || (exp_rsp != '0 && rsp_rdata !== exp_data)) begin
                errors++; $display("FAIL lock_cap_rsp cyc=%0d got rsp=%b data=%h exp rsp=%b data=%h", i, rsp_valid, rsp_rdata, exp_rsp, exp_data); end
            model_commit((i == 8) ? 1 : 0); tick();
        end
        clear_reqs();
        @(negedge CLK); model_commit(-1); tick();
    endtask

    task automatic test_lock_idle();
        // columns: req0 valid, req0 lock, req1 valid, expected grant
        logic [1:0] v0 [5] = '{2'b11, 2'b00, 2'b00, 2'b10, 2'b00};
        logic       v1 [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [N-1:0] ex [5] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b10};
        int g;
        for (int i = 0; i < 5; i++) begin
            set_req(0, v0[i][1], v0[i][0], '0, 9'h010, '0);
            set_req(1, v1[i], 0, 4'hF, 9'h0F0, 32'h5A5A0000 + i);
            @(negedge CLK);
            g = model_pick();
            checks++; if (req_ready !== ex[i] || ram_en !== (ex[i] != '0)) begin
                errors++; $display("FAIL lock_idle cyc=%0d got rdy=%b en=%b exp rdy=%b", i, req_ready, ram_en, ex[i]); end
            model_commit(g); tick();
        end
        clear_reqs();
        @(negedge CLK); model_commit(-1); tick();
    endtask

    task automatic test_random();
        int g;
        logic [N-1:0] er;
        for (int i = 0; i < 8; i++) begin
            clear_reqs();
            set_req(0, 1, 0, 4'hF, 9'h100 + 9'(i), $urandom);
            @(negedge CLK);
            checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL preload cyc=%0d got=%b exp=01", i, req_ready); end
            model_commit(0); tick();
        end
        for (int i = 0; i < 162; i++) begin
            for (int r = 0; r < N; r++) begin
                if (i >= 160) set_req(r, 1, 0, '0, 9'h100 + 9'($urandom_range(0, 7)), '0);
                else set_req(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                             ($urandom_range(0, 1) != 0) ? 4'($urandom) : '0,
                             9'h100 + 9'($urandom_range(0, 7)), $urandom);
            end
            @(negedge CLK);
            g  = model_pick();
            er = (g < 0) ? '0 : (N'(1) << g);
            checks++; if (req_ready !== er || ram_en !== (g >= 0)) begin
                errors++; $display("FAIL random_grant cyc=%0d got rdy=%b en=%b exp rdy=%b", i, req_ready, ram_en, er); end
            if (g >= 0) begin
                checks++; if (ram_a !== req_addr[g*AW +: AW] || ram_we !== req_we[g*BE +: BE] || ram_di !== req_wdata[g*DW +: DW]) begin
                    errors++; $display("FAIL random_mux cyc=%0d got a=%h we=%h di=%h exp a=%h we=%h di=%h", i, ram_a, ram_we, ram_di,
                                       req_addr[g*AW +: AW], req_we[g*BE +: BE], req_wdata[g*DW +: DW]); end
            end
            checks++; if (rsp_valid !== exp_rsp || (exp_rsp != '0 && rsp_rdata !== exp_data)) begin
                errors++; $display("FAIL random_rsp cyc=%0d got rsp=%b data=%h exp rsp=%b data=%h", i, rsp_valid, rsp_rdata, exp_rsp, exp_data); end
            model_commit(g); tick();
        end
        clear_reqs();
        @(negedge CLK);
        checks++; if (rsp_valid !== exp_rsp || (exp_rsp != '0 && rsp_rdata !== exp_data)) begin
            errors++; $display("FAIL random_last_rsp got rsp=%b data=%h exp rsp=%b data=%h", rsp_valid, rsp_rdata, exp_rsp, exp_data); end
        model_commit(-1); tick();
    endtask

    task automatic test_reset_mid_burst();
        set_req(0, 1, 0, '0, 9'h010, '0);
        @(negedge CLK);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_pre got=%b exp=01", req_ready); end
        model_commit(0); tick();
        clear_reqs();
        set_req(1, 1, 1, '0, 9'h1FF, '0);
        @(negedge CLK);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL midrst_grant got=%b exp=10", req_ready); end
        #1 RST_N = 1'b0;
        #1;
        checks++; if (req_ready !== '0 || ram_en !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got rdy=%b en=%b exp rdy=00 en=0", req_ready, ram_en); end
        tick();
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL midrst_rsp got=%b exp=00", rsp_valid); end
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        clear_reqs();
        tick();
        for (int r = 0; r < N; r++) set_req(r, 1, 0, '0, 9'h010, '0);
        @(negedge CLK);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_first_grant got=%b exp=01", req_ready); end
        model_commit(0); tick();
        clear_reqs();
        @(negedge CLK);
        checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== exp_data) begin
            errors++; $display("FAIL midrst_after_rsp got rsp=%b data=%h exp rsp=01 data=%h", rsp_valid, rsp_rdata, exp_data); end
        model_commit(-1); tick();
    endtask

`ifdef DFFRAM_ARB_DUMP_EN
    task automatic test_dump();
        dump_req = 1'b1;
        set_req(0, 1, 0, '0, 9'h010, '0);
        @(negedge CLK);
        checks++; if (req_ready !== '0 || ram_en !== 1'b0) begin
            errors++; $display("FAIL dump_trigger got rdy=%b en=%b exp rdy=00 en=0", req_ready, ram_en); end
        model_commit(-1); tick();
        dump_req = 1'b0;
        @(negedge CLK);
        checks++; if (ram_write !== 1'b1 || ram_en !== 1'b0 || req_ready !== '0 || dump_done !== 1'b0) begin
            errors++; $display("FAIL dump_cycle got wr=%b en=%b rdy=%b done=%b exp wr=1 en=0 rdy=00 done=0", ram_write, ram_en, req_ready, dump_done); end
        model_commit(-1); tick();
        @(negedge CLK);
        checks++; if (ram_write !== 1'b0 || dump_done !== 1'b1 || req_ready !== 2'b01) begin
            errors++; $display("FAIL dump_done got wr=%b done=%b rdy=%b exp wr=0 done=1 rdy=01", ram_write, dump_done, req_ready); end
        model_commit(model_pick()); tick();
        clear_reqs();
        @(negedge CLK);
        checks++; if (dump_done !== 1'b0 || rsp_valid !== 2'b01 || rsp_rdata !== exp_data) begin
            errors++; $display("FAIL dump_after got done=%b rsp=%b data=%h exp done=0 rsp=01 data=%h", dump_done, rsp_valid, rsp_rdata, exp_data); end
        model_commit(-1); tick();
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog expired before end of run");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef DFFRAM_ARB_DUMP_EN
        dump_req = 1'b0;
`endif
        test_reset();
        test_single_read();
        test_byte_mask();
        test_contention();
        test_lock_cap();
        test_lock_idle();
        test_random();
        test_reset_mid_burst();
`ifdef DFFRAM_ARB_DUMP_EN
        test_dump();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dffram_arbiter.md
Name: dffram_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one DFFRAM512x32 single-port RAM (1-cycle registered read, byte write enables) between NUM_REQ requesters of the subdivision pipeline.
- Grants at most one access per cycle and returns read data to the owning requester one cycle after grant.
- Supports bounded locked bursts so a requester can stream consecutive accesses without interleaving.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- A_WIDTH, 9, RAM word-address width.
- D_WIDTH, 32, RAM data width; byte-enable width is D_WIDTH/8.
- MAX_LOCK, 8, maximum consecutive grants to one locked requester before forced rotation.

Ports:
- CLK  in  1  clock, all state on posedge.
- RST_N  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  access request per requester.
- req_lock  in  NUM_REQ  request to keep the grant for the next beat.
- req_we  in  NUM_REQ*4  byte write mask per requester; 0 means read.
- req_addr  in  NUM_REQ*A_WIDTH  word address per requester.
- req_wdata  in  NUM_REQ*D_WIDTH  write data per requester.
- req_ready  out  NUM_REQ  one-hot grant; the access is accepted when valid&ready.
- rsp_valid  out  NUM_REQ  one-hot read-data valid.
- rsp_rdata  out  D_WIDTH  read data, shared bus.
- ram_en  out  1  to RAM EN0.
- ram_we  out  4  to RAM WE0.
- ram_a  out  A_WIDTH  to RAM A0.
- ram_di  out  D_WIDTH  to RAM Di0.
- ram_do  in  D_WIDTH  from RAM Do0.
- ram_write  out  1  to RAM write (dump) pin.

Behaviour:
- Reset values: rr_ptr=0, state=ARB, lock_cnt=0, owner=0, rsp_valid=0, ram_write=0. req_ready and ram_* are 0 while RST_N is low.
- States:
  - ARB: pick the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - LOCKED: only the owner is eligible.
- Grant path, same cycle and combinational from registered state: req_ready[g]=1 and ram_en=1; ram_we, ram_a and ram_di are muxed from requester g. The RAM samples on the next posedge.
- On a granted cycle, rr_ptr <= g+1 (mod NUM_REQ), except in LOCKED, where rr_ptr is unchanged.
- ARB -> LOCKED: when the granted requester has req_lock=1 and MAX_LOCK>1. Set owner<=g and lock_cnt<=1.
- LOCKED:
  - A grant occurs only if req_valid[owner]=1; each grant increments lock_cnt.
  - Exit to ARB when req_lock[owner]=0 at a grant, or when lock_cnt reaches MAX_LOCK (that beat is the last locked beat).
  - Set rr_ptr<=owner+1 on exit.
  - If the owner drops req_valid while lock is held, the RAM idles (ram_en=0). Other requesters stay blocked until the owner releases the lock.
- Read latency:
  - A read granted in cycle N (req_we==0) gives rsp_valid[g]=1 in cycle N+1, with rsp_rdata=ram_do.
  - Writes produce no response.
  - Back-to-back reads give back-to-back responses.
- Idle cycles hold ram_en=0. The RAM then drives Do0=0, and rsp_rdata is don't-care when no rsp_valid is set.
- Simultaneous requests: exactly one grant, chosen by rr_ptr. No requester waits more than NUM_REQ-1 grants, or MAX_LOCK*(NUM_REQ-1) grants when others use lock.
- Reset mid-operation: a pending rsp_valid is dropped, and any lock and the owner are cleared.
- Same-address write then read in the next cycle returns the new data. This is guaranteed by the RAM; the arbiter does no forwarding.

Optional Feature:
- Macro DFFRAM_ARB_DUMP_EN.
- When defined, the block adds inputs dump_req (1) and output dump_done (1), and a DUMP state entered from ARB when dump_req=1 and no lock is held.
  - DUMP cycle 1: no grants, ram_en=0, ram_write=1 for exactly one cycle.
  - Next cycle: dump_done=1 for one cycle, then return to ARB.
  - dump_req must deassert before the block re-enters DUMP; edge detection is registered.
- When undefined: these ports are absent, ram_write is tied 0 and the DUMP state does not exist.

Decomposition:
- Package dffram_arb_pkg holds:
  - A_WIDTH=9, D_WIDTH=32, BE_WIDTH=4.
  - State enum {ARB, LOCKED, DUMP}.
  - Helper function for ceil-log2 of NUM_REQ.
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: valid vector and pointer.
  - Outputs: one-hot grant and index.
  - Instantiated once.

Test Plan:
- Single read: after reset, write 0xDEADBEEF to addr 0x010 from req0 (we=4'hF), then read addr 0x010 -> rsp_valid[0] one cycle after grant, rsp_rdata=0xDEADBEEF.
- Byte mask: write 0x11223344 to addr 0x1FF, then from req1 write 0xAABBCCDD with we=4'b0101, then read -> 0x11BB33DD.
- Contention: req0 and req1 valid continuously with reads -> grants alternate 0,1,0,1 starting with req0. Each rsp_valid appears in the matching requester's bit one cycle later.
- Lock cap, MAX_LOCK=8: req0 holds lock and valid and req1 is valid -> req0 gets exactly 8 grants, then req1 is granted, then req0.
- Reset mid-burst: assert RST_N=0 the cycle after a read grant -> rsp_valid stays 0, req_ready=0 and ram_en=0. After release, the first grant goes to req0.
- DFFRAM_ARB_DUMP_EN: pulse dump_req while idle -> ram_write=1 for exactly 1 cycle with ram_en=0, then dump_done=1 the following cycle. Requests made during DUMP are granted afterwards.
